uart_tx_fifo: RTL
=================

# uart_tx_fifo

Parametrised UART transmitter with an input FIFO. It is the next-generation replacement for the fixed-format sender in the Pico-to-FPGA send path. A producer pushes words through a valid/ready handshake. The block serialises each word onto `o_txd` using the configured frame format: data width, parity mode, stop-bit count and bit period. Frames run back-to-back while the FIFO holds data.

## Interface
- `CLKS_PER_BIT`, default 434: `i_clk` cycles per serial bit; legal range ≥ 2 (434 gives 115200 baud at 50 MHz).
- `DATA_BITS`, default 8: data bits per frame; legal range 5..9.
- `PARITY`, default 0: parity mode; 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: stop bits per frame; 1 or 2.
- `FIFO_AW`, default 3: FIFO address width; depth = 2^FIFO_AW.
- `i_clk`  in  1  system clock; all logic on its rising edge.
- `i_rst`  in  1  reset; synchronous, active-high.
- `i_data`  in  DATA_BITS  word to transmit.
- `i_valid`  in  1  `i_data` is valid.
- `o_ready`  out  1  FIFO can accept a word; registered, equals !full.
- `o_txd`  out  1  serial line; registered, idles high.
- `o_busy`  out  1  serialiser FSM not in IDLE.
- `o_level`  out  FIFO_AW+1  FIFO occupancy, 0..2^FIFO_AW.

## Operation
- Push: a word is written on any edge where `i_valid & o_ready`. `i_valid` while `o_ready`=0 is ignored and the word is lost; the producer must hold it.
- FIFO: circular buffer with FIFO_AW-bit pointers that wrap modulo depth.
  - Push and pop on the same edge leave `o_level` unchanged.
  - A push while full is impossible, because `o_ready`=0.
  - When full, a same-cycle pop does not re-enable a push in that cycle; `o_ready` rises on the following edge.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: `o_txd`=1. If the FIFO is non-empty, pop the head into the shift register, drive `o_txd`=0 and go to START.
  - START: hold 0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: send DATA_BITS bits LSB first, each held CLKS_PER_BIT cycles. After the last bit, go to PARITY if PARITY≠0, else to STOP.
  - PARITY: send the parity bit for CLKS_PER_BIT cycles.
    - Even: the bit is the XOR of the data bits.
    - Odd: the bit is the inverted XOR of the data bits.
  - STOP: send 1 for STOP_BITS×CLKS_PER_BIT cycles. On the final cycle:
    - if the FIFO is non-empty, pop and go directly to START, with `o_txd`=0 on the next cycle;
    - otherwise go to IDLE.
- Counters:
  - bit-period counter: $clog2(CLKS_PER_BIT) bits;
  - bit index: $clog2(DATA_BITS+1) bits;
  - stop counter: covers STOP_BITS×CLKS_PER_BIT.
- `o_busy` = (state ≠ IDLE).
- Parameter values outside their legal range are an elaboration error (`$error` in a generate check).

## Timing
- Reset values: `o_txd`=1, `o_busy`=0, `o_ready`=1, `o_level`=0, FSM=IDLE, FIFO pointers=0.
- Reset mid-frame aborts the frame and flushes the FIFO. `o_txd` returns to 1 on the edge after `i_rst` is sampled high.
- Pushes on edges where `i_rst`=1 are discarded.
- Latency: a word accepted at edge k into an empty FIFO with FSM in IDLE gives `o_txd`=0 from edge k+1. `o_level` reads 1 only during cycle k→k+1 and returns to 0 at k+1.
- Frame length = (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles, exactly.
- Back-to-back frames have zero idle cycles between the last stop bit and the next start bit.
- `o_txd` changes only at bit boundaries; it has no glitches because it is a register output.
- `o_ready` falls on the edge of the push that fills the FIFO. It rises on the edge after the pop from full.

## Test plan
- Reset and idle: hold `i_rst` 3 cycles, then release → `o_txd`=1, `o_ready`=1, `o_busy`=0, `o_level`=0; no activity for 200 cycles.
- Single frame, defaults with CLKS_PER_BIT=5: push 0x55 at edge k → `o_txd`=0 for cycles k+1..k+5, then 1,0,1,0,1,0,1,0 at 5 cycles each, then 1. `o_busy` high for exactly 50 cycles.
- Parity and stop bits, DATA_BITS=7, PARITY=1, STOP_BITS=2, CLKS_PER_BIT=5: push 0x03 → parity bit 1 (two ones, odd parity). Frame is 11 bits = 55 cycles. Repeat with PARITY=2 → parity bit 0.
- FIFO full and back-to-back, FIFO_AW=2: push 6 words with `i_valid` held high.
  - First word pops immediately; `o_ready`=0 after 5 accepted words with `o_level`=4; the 6th word stalls until the first pop from full.
  - Six contiguous frames with no gap; words 0x01..0x06 decoded in order.
- Simultaneous push/pop: push a word on the exact STOP-final edge while the FIFO holds 1 word → `o_level` unchanged, the next start bit follows with no gap, and no word is lost or duplicated.
- Reset mid-operation: assert `i_rst` for 1 cycle during the DATA state with 3 words queued → `o_txd`=1 next edge, `o_level`=0. After release, a new push of 0xA5 transmits correctly, and none of the old words appear.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// Producer-side bus of the UART transmitter: push handshake plus line and status outputs.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS = 8,
  parameter int FIFO_AW   = 3
);
  logic [DATA_BITS-1:0] i_data;
  logic                 i_valid;
  logic                 o_ready;
  logic                 o_txd;
  logic                 o_busy;
  logic [FIFO_AW:0]     o_level;

  modport master (output i_data, i_valid, input o_ready, o_txd, o_busy, o_level);
  modport slave  (input i_data, i_valid, output o_ready, o_txd, o_busy, o_level);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a circular FIFO; frames with configurable data width,
// parity and stop bits run back-to-back while words are queued.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_AW      = 3
) (
  input logic           i_clk,
  input logic           i_rst,
  uart_tx_fifo_if.slave bus
);
  localparam int DEPTH    = 1 << FIFO_AW;
  localparam int LW       = FIFO_AW + 1;
  localparam int CW       = $clog2(CLKS_PER_BIT);
  localparam int BW       = $clog2(DATA_BITS + 1);
  localparam int STOP_LEN = STOP_BITS * CLKS_PER_BIT;
  localparam int SW       = $clog2(STOP_LEN);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic [SW-1:0] STOP_LAST = SW'(STOP_LEN - 1);
  localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("CLKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
    $error("DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $error("PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("STOP_BITS must be 1 or 2");
  end
  if (FIFO_AW < 1) begin : g_bad_aw
    $error("FIFO_AW must be >= 1");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [SW-1:0]        stop_q, stop_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 txd_q, txd_d;
  logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]        level_q, level_d;
  logic                 ready_q, ready_d;
  logic [DATA_BITS-1:0] mem_q [DEPTH];

  logic                 push, pop, not_empty, cnt_last;
  logic [DATA_BITS-1:0] head;

  assign push      = bus.i_valid & ready_q;
  assign not_empty = (level_q != '0);
  assign cnt_last  = (cnt_q == CNT_LAST);
  assign head      = mem_q[rd_ptr_q];

  // ready is registered from the next level, so a pop from full re-opens
  // the FIFO only after the edge that performs it
  always_comb begin
    wr_ptr_d = wr_ptr_q + FIFO_AW'(push);
    rd_ptr_d = rd_ptr_q + FIFO_AW'(pop);
    level_d  = level_q + LW'(push) - LW'(pop);
    ready_d  = (level_d != FULL_LVL);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    par_d   = par_q;
    txd_d   = txd_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (not_empty) begin
          pop     = 1'b1;
          shift_d = head;
          par_d   = (PARITY == 1) ? ~^head : ^head;
          txd_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_last) begin
          cnt_d   = '0;
          bit_d   = '0;
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_last) begin
          cnt_d = '0;
          if (bit_q != BIT_LAST) begin
            bit_d   = bit_q + BW'(1);
            txd_d   = shift_q[0];
            shift_d = shift_q >> 1;
          end else if (PARITY != 0) begin
            txd_d   = par_q;
            state_d = S_PARITY;
          end else begin
            txd_d   = 1'b1;
            stop_d  = '0;
            state_d = S_STOP;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_PARITY: begin
        if (cnt_last) begin
          cnt_d   = '0;
          txd_d   = 1'b1;
          stop_d  = '0;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (stop_q == STOP_LAST) begin
          // chain straight into the next start bit when more data is queued
          if (not_empty) begin
            pop     = 1'b1;
            shift_d = head;
            par_d   = (PARITY == 1) ? ~^head : ^head;
            txd_d   = 1'b0;
            cnt_d   = '0;
            state_d = S_START;
          end else begin
            txd_d   = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          stop_d = stop_q + SW'(1);
        end
      end
      default: begin
        txd_d   = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      stop_q   <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      txd_q    <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      stop_q   <= stop_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      txd_q    <= txd_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ready_q  <= ready_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push && !i_rst) mem_q[wr_ptr_q] <= bus.i_data;
  end

  assign bus.o_ready = ready_q;
  assign bus.o_txd   = txd_q;
  assign bus.o_busy  = (state_q != S_IDLE);
  assign bus.o_level = level_q;
endmodule
